uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter SYSCLK_RATE, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bits/s.
REQ-003 SHALL have port SysClk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Req0  input  1  requester 0 has a byte to send.
REQ-006 SHALL have port Data0  input  8  requester 0 byte, valid while Req0 is high.
REQ-007 SHALL have port Ack0  output  1  one-cycle pulse: Data0 accepted.
REQ-008 SHALL have ports Req1, Data1, Ack1 with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port Tx  output  1  serial line, idle high.
REQ-010 SHALL have port Busy  output  1  high whenever a frame is in progress.
REQ-011 SHALL have port Owner  output  1  index of the requester whose frame is in progress or was sent last.

Function
REQ-012 SHALL define BIT_DIV = SYSCLK_RATE / BAUD_RATE (integer division) SysClk cycles per serial bit; a parameter set giving BIT_DIV < 2, or BAUD_RATE = 0, SHALL fail elaboration with an error.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (only if configured), STOP.
REQ-014 In IDLE, on a rising edge with Req0 or Req1 high: latch the granted Data into the shift register, pulse the granted Ack for exactly the following cycle, update Owner, go to START.
REQ-015 Arbitration: single request wins; if both are high, the requester not equal to Owner wins (round robin).
REQ-016 Tx SHALL be 0 for exactly BIT_DIV cycles in START, starting the cycle after the grant edge.
REQ-017 DATA SHALL send the 8 bits LSB first, each for exactly BIT_DIV cycles, using a 3-bit bit index counting 0..7 that wraps to 0 on exit.
REQ-018 STOP SHALL drive Tx = 1 for BIT_DIV cycles, then go to IDLE; a request pending at that point is granted on the first IDLE edge, giving exactly one idle-high cycle between frames.
REQ-019 Busy SHALL be high in every state except IDLE; Tx SHALL be 1 in IDLE.
REQ-020 Requests, and changes to Data0/Data1, are ignored while Busy; Data is sampled only at the grant edge.
REQ-021 A requester holding Req high after its Ack SHALL be treated as a new request.
REQ-022 The baud counter SHALL count 0..BIT_DIV-1, reload to 0 on every bit boundary, and be held at 0 in IDLE.

Reset
REQ-023 While Rst is high, regardless of SysClk: state = IDLE, Tx = 1, Busy = 0, Ack0 = Ack1 = 0, Owner = 1 (so Req0 wins the first tie), counters = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no resume; the aborted byte is not re-acked.

Configuration
REQ-025 Macro UART_TX_SCHEDULER_PARITY_EN defined: PARITY state between DATA and STOP, lasting BIT_DIV cycles, with Tx = even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-026 Macro UART_TX_SCHEDULER_PARITY_EN undefined: no PARITY state, DATA goes directly to STOP; frame = 10 bits.

Verification (SYSCLK_RATE=100, BAUD_RATE=10, so BIT_DIV=10)
REQ-027 Req0=1, Data0=8'hA5 from idle -> Ack0 high 1 cycle; Tx pattern 0,1,0,1,0,0,1,0,1,[0 if parity],1, each level held 10 cycles; Busy high 100 cycles (110 with parity).
REQ-028 Req0 and Req1 held high continuously after reset -> grants alternate 0,1,0,1; one idle cycle between frames; Owner toggles at each grant.
REQ-029 Req1 alone with Data1=8'hFF, Data1 changed to 8'h00 mid-frame -> transmitted bits are all 1s.
REQ-030 Rst pulsed at cycle 35 of a frame -> Tx=1, Busy=0 asynchronously; the next request starts a fresh start bit.
REQ-031 Parity build, Data0=8'h07 -> parity bit 1; Data0=8'h03 -> parity bit 0.
REQ-032 Request arriving in the last STOP cycle -> granted on the first IDLE edge; no Ack while Busy.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester round-robin UART transmitter; parity bit enabled by UART_TX_SCHEDULER_PARITY_EN
module uart_tx_scheduler #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       SysClk,
    input  logic       Rst,
    input  logic       Req0,
    input  logic [7:0] Data0,
    output logic       Ack0,
    input  logic       Req1,
    input  logic [7:0] Data1,
    output logic       Ack1,
    output logic       Tx,
    output logic       Busy,
    output logic       Owner
);

    // Guard the division so a zero baud rate reaches the error below instead of dividing by zero
    localparam int BIT_DIV = (BAUD_RATE == 0) ? 0 : SYSCLK_RATE / BAUD_RATE;
    localparam int CW      = (BIT_DIV < 2) ? 1 : $clog2(BIT_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);

    generate
        if (BAUD_RATE == 0 || BIT_DIV < 2) begin : g_bad_cfg
            $error("uart_tx_scheduler: SYSCLK_RATE/BAUD_RATE must be at least 2 and BAUD_RATE nonzero");
        end
    endgenerate

`ifdef UART_TX_SCHEDULER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           bit_end;
    logic           grant_any;
    logic           winner;

    assign bit_end   = (cnt == CNT_LAST);
    assign grant_any = (state == S_IDLE) && (Req0 || Req1);
    // A tie goes to the requester that did not send last; otherwise the lone requester wins
    assign winner    = (Req0 && Req1) ? ~Owner : Req1;

    // State register; reset drops straight to IDLE, abandoning any frame in flight
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every non-idle state lasts whole bit periods
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_SCHEDULER_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
                end
            end
`ifdef UART_TX_SCHEDULER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: line level and busy flag follow the current state directly
    always_comb begin
        Tx   = 1'b1;
        Busy = 1'b1;
        case (state)
            S_IDLE:   Busy = 1'b0;
            S_START:  Tx   = 1'b0;
            S_DATA:   Tx   = shift_reg[bit_idx];
`ifdef UART_TX_SCHEDULER_PARITY_EN
            S_PARITY: Tx   = ^shift_reg;
`endif
            S_STOP:   Tx   = 1'b1;
            default: begin
                Tx   = 1'b1;
                Busy = 1'b0;
            end
        endcase
    end

    // Datapath: baud counter, bit index, byte capture, grant pulses and owner tracking
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            Ack0      <= 1'b0;
            Ack1      <= 1'b0;
            Owner     <= 1'b1;
        end else begin
            if (state == S_IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // The index wraps from 7 back to 0 as DATA finishes, ready for the next frame
            if (state == S_DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            Ack0 <= grant_any && !winner;
            Ack1 <= grant_any && winner;
            if (grant_any) begin
                shift_reg <= winner ? Data1 : Data0;
                Owner     <= winner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler (SYSCLK_RATE=100, BAUD_RATE=10)
module tb_uart_tx_scheduler;

    localparam int BD = 10;
`ifdef UART_TX_SCHEDULER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       SysClk;
    logic       Rst;
    logic       Req0;
    logic [7:0] Data0;
    logic       Ack0;
    logic       Req1;
    logic [7:0] Data1;
    logic       Ack1;
    logic       Tx;
    logic       Busy;
    logic       Owner;

    typedef struct {
        bit         idx;
        logic [7:0] data;
        int         cut;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   ok;

    uart_tx_scheduler #(.SYSCLK_RATE(100), .BAUD_RATE(10)) dut (
        .SysClk (SysClk),
        .Rst    (Rst),
        .Req0   (Req0),
        .Data0  (Data0),
        .Ack0   (Ack0),
        .Req1   (Req1),
        .Data1  (Data1),
        .Ack1   (Ack1),
        .Tx     (Tx),
        .Busy   (Busy),
        .Owner  (Owner)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    task automatic check(input bit good, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!good) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_ack(input int idx, output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge SysClk);
            if ((idx == 0 && Ack0 === 1'b1) || (idx == 1 && Ack1 === 1'b1)) begin
                got = 1'b1;
                break;
            end
        end
        check(got, $sformatf("ack%0d_wait", idx), 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge SysClk);
            if (Busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        check(idle, "idle_wait", 32'(idle), 32'd1);
        repeat (3) @(negedge SysClk);
    endtask

    // Checks one frame starting at the negedge on which the grant pulse is visible
    task automatic run_frame(input exp_t e, output bit follow);
        logic [NB-1:0] lvl;
        bit            bit_ok;
        logic [1:0]    bad;
        int            k;
        follow = 1'b0;
        lvl[0] = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = e.data[i];
`ifdef UART_TX_SCHEDULER_PARITY_EN
        lvl[9] = ^e.data;
`endif
        lvl[NB-1] = 1'b1;
        check(Ack0 === !e.idx && Ack1 === e.idx, $sformatf("ack_index_%02h", e.data),
              32'({Ack1, Ack0}), e.idx ? 32'd2 : 32'd1);
        check(Owner === e.idx, $sformatf("owner_%02h", e.data), 32'(Owner), 32'(e.idx));
        k = 0;
        for (int b = 0; b < NB; b++) begin
            bit_ok = 1'b1;
            bad    = 2'b00;
            for (int c = 0; c < BD; c++) begin
                if (k > 0) @(negedge SysClk);
                if (e.cut != 0 && k == e.cut) begin
                    check(Tx === 1'b1 && Busy === 1'b0 && Ack0 === 1'b0 && Ack1 === 1'b0,
                          "abort_state", 32'({Tx, Busy}), 32'd2);
                    return;
                end
                if (bit_ok && (Tx !== lvl[b] || Busy !== 1'b1 ||
                               (k > 0 && (Ack0 !== 1'b0 || Ack1 !== 1'b0)))) begin
                    bit_ok = 1'b0;
                    bad    = {Tx, Busy};
                end
                k++;
            end
            check(bit_ok, $sformatf("frame_%02h_bit%0d", e.data, b), 32'(bad), 32'({lvl[b], 1'b1}));
        end
        @(negedge SysClk);
        check(Busy === 1'b0 && Tx === 1'b1 && Ack0 === 1'b0 && Ack1 === 1'b0,
              $sformatf("idle_gap_%02h", e.data), 32'({Tx, Busy, Ack1, Ack0}), 32'h8);
        if (e.b2b) begin
            @(negedge SysClk);
            check(Ack0 === 1'b1 || Ack1 === 1'b1, $sformatf("b2b_grant_after_%02h", e.data),
                  32'({Ack1, Ack0}), 32'd1);
            follow = 1'b1;
        end
    endtask

    // Monitor: whenever a grant pulse appears, pop the expected frame and check it end to end
    initial begin : monitor
        exp_t e;
        bit   follow;
        follow = 1'b0;
        forever begin
            if (!follow) @(negedge SysClk);
            follow = 1'b0;
            if (Ack0 === 1'b1 || Ack1 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_ack", 32'({Ack1, Ack0}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    run_frame(e, follow);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Data0 = 8'h00; Data1 = 8'h00;
        repeat (2) @(negedge SysClk);
        check(Tx === 1'b1 && Busy === 1'b0 && Ack0 === 1'b0 && Ack1 === 1'b0 && Owner === 1'b1,
              "reset_state", 32'({Tx, Busy, Ack1, Ack0, Owner}), 32'h11);
        Rst = 1'b0;
        @(negedge SysClk);

        // Single byte from requester 0
        exp_q.push_back('{1'b0, 8'hA5, 0, 1'b0});
        Req0 = 1'b1; Data0 = 8'hA5;
        wait_ack(0, ok);
        Req0 = 1'b0;
        wait_idle();

        // Reset restores Owner so requester 0 wins the first tie; both held -> alternation
        Rst = 1'b1;
        @(negedge SysClk);
        Rst = 1'b0;
        check(Owner === 1'b1, "owner_after_reset", 32'(Owner), 32'd1);
        exp_q.push_back('{1'b0, 8'h3C, 0, 1'b1});
        exp_q.push_back('{1'b1, 8'hC3, 0, 1'b1});
        exp_q.push_back('{1'b0, 8'h3C, 0, 1'b1});
        exp_q.push_back('{1'b1, 8'hC3, 0, 1'b0});
        Req0 = 1'b1; Data0 = 8'h3C; Req1 = 1'b1; Data1 = 8'hC3;
        wait_ack(0, ok);
        wait_ack(1, ok);
        wait_ack(0, ok);
        wait_ack(1, ok);
        Req0 = 1'b0; Req1 = 1'b0;
        wait_idle();

        // Data changes while busy are ignored
        exp_q.push_back('{1'b1, 8'hFF, 0, 1'b0});
        Req1 = 1'b1; Data1 = 8'hFF;
        wait_ack(1, ok);
        Req1 = 1'b0;
        repeat (20) @(negedge SysClk);
        Data1 = 8'h00;
        wait_idle();

        // Reset at frame cycle 35 aborts; next request begins a fresh frame
        exp_q.push_back('{1'b0, 8'h5A, 35, 1'b0});
        Req0 = 1'b1; Data0 = 8'h5A;
        wait_ack(0, ok);
        Req0 = 1'b0;
        repeat (34) @(negedge SysClk);
        #2 Rst = 1'b1;
        #1 check(Tx === 1'b1 && Busy === 1'b0, "async_reset", 32'({Tx, Busy}), 32'd2);
        @(negedge SysClk);
        repeat (2) @(negedge SysClk);
        Rst = 1'b0;
        @(negedge SysClk);
        exp_q.push_back('{1'b0, 8'h81, 0, 1'b0});
        Req0 = 1'b1; Data0 = 8'h81;
        wait_ack(0, ok);
        Req0 = 1'b0;
        wait_idle();

        // Request raised in the last STOP cycle is granted after exactly one idle cycle
        exp_q.push_back('{1'b1, 8'h96, 0, 1'b1});
        exp_q.push_back('{1'b0, 8'h42, 0, 1'b0});
        Req1 = 1'b1; Data1 = 8'h96;
        wait_ack(1, ok);
        Req1 = 1'b0;
        repeat (NB * BD - 1) @(negedge SysClk);
        Req0 = 1'b1; Data0 = 8'h42;
        wait_ack(0, ok);
        Req0 = 1'b0;
        wait_idle();

        // Parity-sensitive bytes (odd and even bit counts)
        exp_q.push_back('{1'b0, 8'h07, 0, 1'b0});
        Req0 = 1'b1; Data0 = 8'h07;
        wait_ack(0, ok);
        Req0 = 1'b0;
        wait_idle();
        exp_q.push_back('{1'b0, 8'h03, 0, 1'b0});
        Req0 = 1'b1; Data0 = 8'h03;
        wait_ack(0, ok);
        Req0 = 1'b0;
        wait_idle();

        check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
